// File: rtl/common_apb3_pkg.sv
// Shared types and constants for the APB3 address decoder.
package common_apb3_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        RESP     = 2'd3
    } apb_dec_state_t;

    localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

    // Width of a slave index; never below one bit so single-slave builds still elaborate.
    function automatic int idx_width(input int num_slv);
        if (num_slv > 1) begin
            return $clog2(num_slv);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/common_apb3_decoder_if.sv
// APB3 bus bundle between the SoC master and the decoder's upstream port.
interface common_apb3_decoder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERROR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERROR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERROR
    );
endinterface

// File: rtl/common_apb3_decoder.sv
// Single-master APB3 decoder: window select, window-relative address, miss and
// timeout errors so a hung slave can never lock the CPU bus.
module common_apb3_decoder
    import common_apb3_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLV     = 3,
    parameter int SLV_SHIFT   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    common_apb3_decoder_if.slave          m,
    output logic [NUM_SLV-1:0]            s_PSEL,
    output logic                          s_PENABLE,
    output logic                          s_PWRITE,
    output logic [ADDR_WIDTH-1:0]         s_PADDR,
    output logic [DATA_WIDTH-1:0]         s_PWDATA,
    input  logic [NUM_SLV-1:0]            s_PREADY,
    input  logic [NUM_SLV-1:0]            s_PSLVERROR,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] s_PRDATA,
    output logic                          timeout_pulse,
    output logic [ADDR_WIDTH-1:0]         err_addr
);

    localparam int IDX_W = idx_width(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int SEL_W = ADDR_WIDTH - SLV_SHIFT;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_dec_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  timeout_s;
    logic [SEL_W-1:0]      sel_idx_s;
    logic [NUM_SLV-1:0]    s_psel_s;

    // Next-state, request latch and response capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        slverr_d   = slverr_q;
        err_addr_d = err_addr_q;
        timeout_s  = 1'b0;
        sel_idx_s  = m.PADDR[ADDR_WIDTH-1:SLV_SHIFT];
        case (state_q)
            IDLE: begin
                if (m.PSEL && !m.PENABLE) begin
                    addr_d  = m.PADDR;
                    write_d = m.PWRITE;
                    wdata_d = m.PWDATA;
                    if (32'(sel_idx_s) < NUM_SLV) begin
                        idx_d   = IDX_W'(sel_idx_s);
                        state_d = S_SETUP;
                    end else begin
                        rdata_d    = '0;
                        slverr_d   = 1'b1;
                        err_addr_d = m.PADDR;
                        state_d    = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // A slave answering on the last allowed cycle beats the timeout.
                if (s_PREADY[idx_q]) begin
                    rdata_d  = s_PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
                    slverr_d = s_PSLVERROR[idx_q];
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d    = DATA_WIDTH'(ERR_DATA);
                    slverr_d   = 1'b1;
                    err_addr_d = addr_q;
                    timeout_s  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            slverr_q   <= slverr_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Slave select decoded purely from flops, so it never follows master inputs.
    always_comb begin
        s_psel_s = '0;
        if ((state_q == S_SETUP) || (state_q == S_ACCESS)) begin
            s_psel_s[idx_q] = 1'b1;
        end else begin
            s_psel_s = '0;
        end
    end

    assign s_PSEL        = s_psel_s;
    assign s_PENABLE     = (state_q == S_ACCESS);
    assign s_PWRITE      = write_q;
    assign s_PADDR       = {{SEL_W{1'b0}}, addr_q[SLV_SHIFT-1:0]};
    assign s_PWDATA      = wdata_q;
    assign m.PREADY      = (state_q == RESP);
    assign m.PRDATA      = rdata_q;
    assign m.PSLVERROR   = (state_q == RESP) && slverr_q;
    assign timeout_pulse = timeout_s;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_common_apb3_decoder.sv
// Directed bench for common_apb3_decoder with a queue-based response scoreboard.
module tb_common_apb3_decoder;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int TMO = 16;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] eaddr;
        bit          tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    common_apb3_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

    logic [NS-1:0]    s_psel;
    logic             s_penable;
    logic             s_pwrite;
    logic [AW-1:0]    s_paddr;
    logic [DW-1:0]    s_pwdata;
    logic [NS-1:0]    s_pready  = '0;
    logic [NS-1:0]    s_pslverr = '0;
    logic [NS*DW-1:0] s_prdata  = '0;
    logic             timeout_pulse;
    logic [AW-1:0]    err_addr;

    common_apb3_decoder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS), .SLV_SHIFT(8), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m(m_if),
        .s_PSEL(s_psel), .s_PENABLE(s_penable), .s_PWRITE(s_pwrite),
        .s_PADDR(s_paddr), .s_PWDATA(s_pwdata),
        .s_PREADY(s_pready), .s_PSLVERROR(s_pslverr), .s_PRDATA(s_prdata),
        .timeout_pulse(timeout_pulse), .err_addr(err_addr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = -1;
    logic [15:0] last_err_addr = 16'h0000;
    exp_t exp_q[$];
    exp_t mon_e;

    int          sl_sel = 0;
    int          sl_wait = 0;
    bit          sl_resp = 1'b1;
    logic [31:0] sl_rdata = 32'h0;
    logic        sl_err = 1'b0;
    int          acc_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: selected slave answers after sl_wait access cycles; others always
    // shout ready with error and junk data, which the decoder must ignore.
    always @(posedge clk) begin
        #1;
        if ((|s_psel) && s_penable) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
        for (int k = 0; k < NS; k++) begin
            if (k == sl_sel) begin
                s_pready[k]            = sl_resp && (acc_cnt == sl_wait + 1);
                s_pslverr[k]           = sl_err;
                s_prdata[k*DW +: DW]   = sl_rdata;
            end else begin
                s_pready[k]            = 1'b1;
                s_pslverr[k]           = 1'b1;
                s_prdata[k*DW +: DW]   = 32'hDEAD_0000 + k;
            end
        end
    end

    // Monitor: compare every master completion against the scoreboard head.
    always @(negedge clk) begin
        if (timeout_pulse) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
        end
        if (m_if.PREADY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pready", m_if.PREADY, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_cycle", cyc, mon_e.cyc);
                chk("resp_rdata", m_if.PRDATA, mon_e.rdata);
                chk("resp_slverr", m_if.PSLVERROR, mon_e.err);
                chk("resp_err_addr", err_addr, mon_e.eaddr);
                chk("resp_psel_low", {s_psel, s_penable}, 4'b0000);
                if (mon_e.tmo) chk("pulse_cycle", pulse_cyc, mon_e.cyc - 1);
            end
        end
    end

    task automatic xfer(input logic [15:0] addr, input bit wr, input logic [31:0] wd,
                        input int sel, input int wt, input bit resp,
                        input logic [31:0] rd, input bit serr,
                        input int lat, input logic [31:0] exp_rd, input bit exp_err,
                        input bit tmo, input logic [2:0] exp_psel);
        exp_t e;
        int n;
        sl_sel = sel; sl_wait = wt; sl_resp = resp; sl_rdata = rd; sl_err = serr;
        m_if.PADDR = addr; m_if.PWRITE = wr; m_if.PWDATA = wd;
        m_if.PSEL = 1'b1; m_if.PENABLE = 1'b0;
        if (tmo || lat == 1) last_err_addr = addr;
        e.cyc = cyc + lat; e.rdata = exp_rd; e.err = exp_err;
        e.eaddr = last_err_addr; e.tmo = tmo;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("setup_psel", {s_psel, s_penable}, {exp_psel, 1'b0});
        chk("setup_paddr", s_paddr, {8'h00, addr[7:0]});
        chk("setup_pwdata", {s_pwrite, s_pwdata}, {wr, wd});
        m_if.PENABLE = 1'b1;
        n = 0;
        while (!m_if.PREADY && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_bound", m_if.PREADY, 1'b1);
        @(posedge clk); #1;
        m_if.PSEL = 1'b0; m_if.PENABLE = 1'b0;
    endtask

    initial begin
        m_if.PADDR = '0; m_if.PWRITE = 1'b0; m_if.PWDATA = '0;
        m_if.PSEL = 1'b0; m_if.PENABLE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_master", {m_if.PREADY, m_if.PSLVERROR, m_if.PRDATA}, 34'h0);
        chk("rst_slave", {s_psel, s_penable, timeout_pulse}, 5'b0);
        chk("rst_err_addr", err_addr, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(16'h0104, 1'b1, 32'h1234_5678, 1, 0, 1'b1, 32'h0000_1111, 1'b0,
             3, 32'h0000_1111, 1'b0, 1'b0, 3'b010);
        xfer(16'h0214, 1'b0, 32'h0, 2, 4, 1'b1, 32'hCAFE_F00D, 1'b0,
             7, 32'hCAFE_F00D, 1'b0, 1'b0, 3'b100);
        xfer(16'h0300, 1'b0, 32'h0, 3, 0, 1'b1, 32'h0, 1'b0,
             1, 32'h0, 1'b1, 1'b0, 3'b000);
        xfer(16'h0010, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0,
             TMO + 2, 32'hBAD0_BAD0, 1'b1, 1'b1, 3'b001);
        xfer(16'h0120, 1'b1, 32'hA5A5_5A5A, 1, 2, 1'b1, 32'h55AA_55AA, 1'b1,
             5, 32'h55AA_55AA, 1'b1, 1'b0, 3'b010);
        xfer(16'h0008, 1'b0, 32'h0, 0, TMO - 1, 1'b1, 32'h1357_9BDF, 1'b0,
             TMO + 2, 32'h1357_9BDF, 1'b0, 1'b0, 3'b001);
        xfer(16'h02FC, 1'b0, 32'h0, 2, TMO - 2, 1'b1, 32'h2468_ACE0, 1'b0,
             TMO + 1, 32'h2468_ACE0, 1'b0, 1'b0, 3'b100);
        xfer(16'hFF00, 1'b1, 32'h0F0F_0F0F, 3, 0, 1'b1, 32'h0, 1'b0,
             1, 32'h0, 1'b1, 1'b0, 3'b000);

        // Reset while the slave is in its access phase.
        sl_sel = 2; sl_wait = 10; sl_resp = 1'b1; sl_rdata = 32'h7777_7777; sl_err = 1'b0;
        m_if.PADDR = 16'h0208; m_if.PWRITE = 1'b1; m_if.PWDATA = 32'h1111_2222;
        m_if.PSEL = 1'b1; m_if.PENABLE = 1'b0;
        @(posedge clk); #1;
        m_if.PENABLE = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_access", {s_psel, s_penable}, 4'b1001);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_slave", {s_psel, s_penable}, 4'b0000);
        chk("post_rst_err_addr", err_addr, 16'h0000);
        rst = 1'b0;
        m_if.PSEL = 1'b0; m_if.PENABLE = 1'b0;
        last_err_addr = 16'h0000;
        repeat (14) @(posedge clk);
        #1;

        xfer(16'h0204, 1'b0, 32'h0, 2, 1, 1'b1, 32'h0BAD_F00D, 1'b0,
             4, 32'h0BAD_F00D, 1'b0, 1'b0, 3'b100);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("pulse_count", pulse_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
